// File: rtl/jtframe_spi_dwnld_host.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : jtframe_spi_dwnld_host                                          |
// | Function : SPI master that pushes a ROM file into the data_io SPI slave     |
// |            (file index, download start, data, download end transactions). |
// |            JTFRAME_SPI_HOST_RDBACK_EN adds a MISO read-back byte port.      |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module jtframe_spi_dwnld_host #(
    parameter int CLKDIV = 4,
    parameter int LENW   = 25
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [7:0]      file_idx,
    input  logic [LENW-1:0] len,
    input  logic [7:0]      din,
    input  logic            din_valid,
    output logic            din_ready,
    output logic            busy,
    output logic            done,
    output logic            spi_sck,
    output logic            spi_ss2,
    output logic            spi_di,
    input  logic            spi_do
`ifdef JTFRAME_SPI_HOST_RDBACK_EN
    ,
    output logic [7:0]      rd_data,
    output logic            rd_valid
`endif
);

    localparam int                 c_TMR_W    = $clog2(4*CLKDIV);
    localparam logic [c_TMR_W-1:0] c_TMR_ONE  = c_TMR_W'(1);
    localparam logic [c_TMR_W-1:0] c_HALF_END = c_TMR_W'(CLKDIV-1);
    localparam logic [c_TMR_W-1:0] c_GAP_END  = c_TMR_W'(4*CLKDIV-1);

    localparam logic [2:0] c_ST_IDLE  = 3'd0;
    localparam logic [2:0] c_ST_SEL   = 3'd1;
    localparam logic [2:0] c_ST_LOAD  = 3'd2;
    localparam logic [2:0] c_ST_SHIFT = 3'd3;
    localparam logic [2:0] c_ST_DESEL = 3'd4;
    localparam logic [2:0] c_ST_GAP   = 3'd5;
    localparam logic [2:0] c_ST_DONE  = 3'd6;

    logic [2:0]         r_state, w_state_nx;
    logic [c_TMR_W-1:0] r_tmr, w_tmr_nx;
    logic [2:0]         r_bit, w_bit_nx;
    logic               r_phase, w_phase_nx;
    logic [7:0]         r_shift, w_shift_nx;
    logic [1:0]         r_trans, w_trans_nx;
    logic               r_cmd_sent, w_cmd_sent_nx;
    logic [LENW-1:0]    r_cnt, w_cnt_nx;
    logic [7:0]         r_file, w_file_nx;
    logic               r_di, w_di_nx;
    logic               r_sck, r_ss2, r_busy, r_done, r_din_ready;
    logic               w_sck_nx, w_ss2_nx, w_busy_nx, w_done_nx, w_din_ready_nx;
    logic [7:0]         w_cmd_byte, w_arg_byte;
    logic               w_is_data, w_more, w_rise;

    // Command/argument byte of the current transaction
    always_comb begin
        w_cmd_byte = 8'h55;
        w_arg_byte = 8'h00;
        case (r_trans)
            2'd0:    begin w_cmd_byte = 8'h53; w_arg_byte = r_file; end
            2'd1:    begin w_cmd_byte = 8'h55; w_arg_byte = 8'hFF;  end
            2'd2:    begin w_cmd_byte = 8'h54; w_arg_byte = 8'h00;  end
            default: begin w_cmd_byte = 8'h55; w_arg_byte = 8'h00;  end
        endcase
    end

    assign w_is_data = (r_trans == 2'd2) && r_cmd_sent;
    assign w_more    = (r_trans == 2'd2) ? (r_cnt != '0) : !r_cmd_sent;

    always_comb begin
        w_state_nx    = r_state;
        w_tmr_nx      = r_tmr;
        w_bit_nx      = r_bit;
        w_phase_nx    = r_phase;
        w_shift_nx    = r_shift;
        w_trans_nx    = r_trans;
        w_cmd_sent_nx = r_cmd_sent;
        w_cnt_nx      = r_cnt;
        w_file_nx     = r_file;
        w_di_nx       = r_di;
        w_rise        = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                if (start) begin
                    w_state_nx    = c_ST_SEL;
                    w_file_nx     = file_idx;
                    w_cnt_nx      = len;
                    w_trans_nx    = 2'd0;
                    w_cmd_sent_nx = 1'b0;
                end
            end
            c_ST_SEL: w_state_nx = c_ST_LOAD;
            c_ST_LOAD: begin
                w_tmr_nx   = '0;
                w_bit_nx   = 3'd0;
                w_phase_nx = 1'b0;
                if (!w_is_data) begin
                    w_shift_nx = r_cmd_sent ? w_arg_byte : w_cmd_byte;
                    w_di_nx    = w_shift_nx[7];
                    w_state_nx = c_ST_SHIFT;
                end else if (din_valid && r_din_ready) begin
                    w_shift_nx = din;
                    w_di_nx    = din[7];
                    w_cnt_nx   = r_cnt - LENW'(1);
                    w_state_nx = c_ST_SHIFT;
                end
            end
            c_ST_SHIFT: begin
                if (r_tmr != c_HALF_END) begin
                    w_tmr_nx = r_tmr + c_TMR_ONE;
                end else begin
                    w_tmr_nx   = '0;
                    w_phase_nx = ~r_phase;
                    if (!r_phase) begin
                        w_rise = 1'b1;
                    end else if (r_bit != 3'd7) begin
                        w_bit_nx   = r_bit + 3'd1;
                        w_shift_nx = {r_shift[6:0], 1'b0};
                        w_di_nx    = r_shift[6];
                    end else begin
                        w_cmd_sent_nx = 1'b1;
                        w_state_nx    = w_more ? c_ST_LOAD : c_ST_DESEL;
                    end
                end
            end
            c_ST_DESEL: begin
                if (r_tmr != c_HALF_END) begin
                    w_tmr_nx = r_tmr + c_TMR_ONE;
                end else begin
                    w_tmr_nx   = '0;
                    w_state_nx = c_ST_GAP;
                end
            end
            c_ST_GAP: begin
                if (r_tmr != c_GAP_END) begin
                    w_tmr_nx = r_tmr + c_TMR_ONE;
                end else begin
                    w_tmr_nx = '0;
                    if (r_trans == 2'd3) begin
                        w_state_nx = c_ST_DONE;
                    end else begin
                        w_trans_nx    = r_trans + 2'd1;
                        w_cmd_sent_nx = 1'b0;
                        w_state_nx    = c_ST_SEL;
                    end
                end
            end
            c_ST_DONE: w_state_nx = c_ST_IDLE;
            default:   w_state_nx = c_ST_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with it
    always_comb begin
        w_ss2_nx       = !((w_state_nx == c_ST_SEL)   || (w_state_nx == c_ST_LOAD) ||
                           (w_state_nx == c_ST_SHIFT) || (w_state_nx == c_ST_DESEL));
        w_sck_nx       = (w_state_nx == c_ST_SHIFT) && w_phase_nx;
        w_busy_nx      = (w_state_nx != c_ST_IDLE) && (w_state_nx != c_ST_DONE);
        w_done_nx      = (w_state_nx == c_ST_DONE);
        w_din_ready_nx = (w_state_nx == c_ST_LOAD) && (w_trans_nx == 2'd2) && w_cmd_sent_nx;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= c_ST_IDLE;
            r_tmr       <= '0;
            r_bit       <= 3'd0;
            r_phase     <= 1'b0;
            r_shift     <= 8'h00;
            r_trans     <= 2'd0;
            r_cmd_sent  <= 1'b0;
            r_cnt       <= '0;
            r_file      <= 8'h00;
            r_di        <= 1'b0;
            r_sck       <= 1'b0;
            r_ss2       <= 1'b1;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_din_ready <= 1'b0;
        end else begin
            r_state     <= w_state_nx;
            r_tmr       <= w_tmr_nx;
            r_bit       <= w_bit_nx;
            r_phase     <= w_phase_nx;
            r_shift     <= w_shift_nx;
            r_trans     <= w_trans_nx;
            r_cmd_sent  <= w_cmd_sent_nx;
            r_cnt       <= w_cnt_nx;
            r_file      <= w_file_nx;
            r_di        <= w_di_nx;
            r_sck       <= w_sck_nx;
            r_ss2       <= w_ss2_nx;
            r_busy      <= w_busy_nx;
            r_done      <= w_done_nx;
            r_din_ready <= w_din_ready_nx;
        end
    end

    assign spi_sck   = r_sck;
    assign spi_ss2   = r_ss2;
    assign spi_di    = r_di;
    assign busy      = r_busy;
    assign done      = r_done;
    assign din_ready = r_din_ready;

`ifdef JTFRAME_SPI_HOST_RDBACK_EN
    logic [7:0] r_rx;
    logic [7:0] r_rd_data;
    logic       r_rd_valid;

    // MISO is captured on the same clock edge that raises SCK
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx       <= 8'h00;
            r_rd_data  <= 8'h00;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= 1'b0;
            if (w_rise) begin
                r_rx <= {r_rx[6:0], spi_do};
                if (r_bit == 3'd7) begin
                    r_rd_data  <= {r_rx[6:0], spi_do};
                    r_rd_valid <= 1'b1;
                end
            end
        end
    end

    assign rd_data  = r_rd_data;
    assign rd_valid = r_rd_valid;
`else
    logic w_unused_inputs;
    assign w_unused_inputs = spi_do ^ w_rise;
`endif

endmodule
`default_nettype wire

// File: tb/tb_jtframe_spi_dwnld_host.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_jtframe_spi_dwnld_host                                       |
// | Function : Bench for jtframe_spi_dwnld_host with an SPI slave model and a   |
// |            transaction-level reference of the download sequence.           |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_jtframe_spi_dwnld_host;

    localparam int C     = 4;
    localparam int LENW  = 25;
    localparam int LIMIT = 4000;

    logic            clk = 1'b0;
    logic            rst_n = 1'b1;
    logic            start = 1'b0;
    logic [7:0]      file_idx = 8'h00;
    logic [LENW-1:0] len = '0;
    logic [7:0]      din = 8'h00;
    logic            din_valid = 1'b0;
    logic            din_ready, busy, done, spi_sck, spi_ss2, spi_di, spi_do;
`ifdef JTFRAME_SPI_HOST_RDBACK_EN
    logic [7:0]      rd_data;
    logic            rd_valid;
`endif

    jtframe_spi_dwnld_host #(.CLKDIV(C), .LENW(LENW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .file_idx(file_idx), .len(len),
        .din(din), .din_valid(din_valid), .din_ready(din_ready),
        .busy(busy), .done(done), .spi_sck(spi_sck), .spi_ss2(spi_ss2),
        .spi_di(spi_di), .spi_do(spi_do)
`ifdef JTFRAME_SPI_HOST_RDBACK_EN
        , .rd_data(rd_data), .rd_valid(rd_valid)
`endif
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // SPI slave model: collects bytes on SCK rises and byte counts per window
    logic [7:0] rx_sh = 8'h00;
    int         rx_bits = 0;
    int         win_bytes = 0;
    logic [7:0] rx_q[$];
    int         win_q[$];
    logic [7:0] rb_pat = 8'h5A;

    assign spi_do = rb_pat[3'(7 - rx_bits)];

    always @(negedge spi_ss2) begin
        rx_bits   = 0;
        win_bytes = 0;
    end
    always @(posedge spi_sck) begin
        if (spi_ss2 === 1'b0) begin
            rx_sh = {rx_sh[6:0], spi_di};
            rx_bits++;
            if (rx_bits == 8) begin
                rx_q.push_back(rx_sh);
                win_bytes++;
                rx_bits = 0;
            end
        end
    end
    always @(posedge spi_ss2) win_q.push_back(win_bytes);

    // Protocol monitors: SCK high phase length, SCK only inside a window, flat stalls
    int hi_run = 0, tim_err = 0, stall_err = 0, stall_cyc = 0, rd_pulses = 0, rd_bad = 0;
    always @(negedge clk) begin
        if (!rst_n) begin
            hi_run = 0;
        end else begin
            if (spi_sck === 1'b1) begin
                hi_run++;
                if (spi_ss2 !== 1'b0) tim_err++;
            end else begin
                if (hi_run != 0 && hi_run != C) tim_err++;
                hi_run = 0;
            end
            if (din_ready === 1'b1 && din_valid === 1'b0) begin
                stall_cyc++;
                if (spi_sck !== 1'b0 || spi_ss2 !== 1'b0) stall_err++;
            end
`ifdef JTFRAME_SPI_HOST_RDBACK_EN
            if (rd_valid === 1'b1) begin
                rd_pulses++;
                if (rd_data !== 8'h5A) rd_bad++;
            end
`endif
        end
    end

    logic [7:0] data_q[$];

    // Done arrives after 4x(select + deselect + gap) plus 16*C+1 per byte, plus stalls
    function automatic int exp_done(input int n);
        return 4*(1 + 5*C) + (7 + n)*(16*C + 1) + 1;
    endfunction

    task automatic fill_rand(input int n);
        data_q.delete();
        for (int i = 0; i < n; i++) data_q.push_back(8'($urandom));
    endtask

    task automatic run_dl(input logic [7:0] fi, input int n, input int stall_at, input int stall_n,
                          input bit rnd, input int extra_t, input int abort_bytes);
        int idx, waits, ndone, done_t, stall_left, st0, te0, se0, rp0, rb0;
        bit withheld, aborted;
        logic [7:0] exp_q[$];
        idx = 0; waits = 0; ndone = 0; done_t = -1; stall_left = stall_n; aborted = 0;
        st0 = stall_cyc; te0 = tim_err; se0 = stall_err; rp0 = rd_pulses; rb0 = rd_bad;
        rx_q.delete();
        win_q.delete();
        @(posedge clk); #1;
        file_idx  = fi;
        len       = LENW'(n);
        start     = 1'b1;
        din_valid = 1'b0;
        for (int t = 0; t < LIMIT; t++) begin
            @(negedge clk);
            if (din_valid && din_ready === 1'b1) idx++;
            if (done === 1'b1) begin
                ndone++;
                if (done_t < 0) begin
                    done_t = t;
                    check("busy_at_done", 32'(busy), 32'd0);
                end
            end
            if (t == 1) check("ss2_after_start", 32'(spi_ss2), 32'd0);
            if (abort_bytes > 0 && rx_q.size() >= abort_bytes) begin
                aborted = 1;
                break;
            end
            if (done_t >= 0 && t >= done_t + 8) break;
            @(posedge clk); #1;
            start    = (t + 1 == extra_t);
            withheld = 0;
            if (idx < n && din_ready === 1'b1) begin
                if (idx == stall_at && stall_left > 0) begin
                    withheld = 1;
                    stall_left--;
                end else if (rnd && $urandom_range(0, 2) == 0) begin
                    withheld = 1;
                end
                if (withheld) waits++;
            end
            din       = (idx < n) ? data_q[idx] : 8'($urandom);
            din_valid = (idx < n) && !withheld;
        end
        start     = 1'b0;
        din_valid = 1'b0;
        if (!aborted) begin
            exp_q = '{8'h53, fi, 8'h55, 8'hFF, 8'h54};
            for (int i = 0; i < n; i++) exp_q.push_back(data_q[i]);
            exp_q.push_back(8'h55);
            exp_q.push_back(8'h00);
            check("done_cycle", done_t, exp_done(n) + waits);
            check("done_count", ndone, 1);
            check("windows", win_q.size(), 4);
            for (int i = 0; i < win_q.size() && i < 4; i++)
                check($sformatf("win%0d_bytes", i), win_q[i], (i == 2) ? 1 + n : 2);
            check("byte_count", rx_q.size(), exp_q.size());
            for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++)
                check($sformatf("byte%0d", i), rx_q[i], exp_q[i]);
            check("sck_timing", tim_err - te0, 0);
            check("stall_flat", stall_err - se0, 0);
            if (stall_n > 0) check("stall_cycles", stall_cyc - st0, stall_n);
`ifdef JTFRAME_SPI_HOST_RDBACK_EN
            check("rd_pulses", rd_pulses - rp0, exp_q.size());
            check("rd_data", rd_bad - rb0, 0);
`endif
        end
    endtask

    initial begin
        #2 rst_n = 1'b0;
        #1;
        check("rst_sck", 32'(spi_sck), 32'd0);
        check("rst_ss2", 32'(spi_ss2), 32'd1);
        check("rst_di", 32'(spi_di), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_din_ready", 32'(din_ready), 32'd0);
`ifdef JTFRAME_SPI_HOST_RDBACK_EN
        check("rst_rd_data", 32'(rd_data), 32'd0);
        check("rst_rd_valid", 32'(rd_valid), 32'd0);
`endif
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Basic download
        data_q = '{8'hA5, 8'h3C, 8'h01};
        run_dl(8'h02, 3, -1, 0, 1'b0, 0, 0);

        // Long stall before the second data byte
        fill_rand(3);
        run_dl(8'h11, 3, 1, 100, 1'b0, 0, 0);

        // Empty file
        data_q.delete();
        run_dl(8'h07, 0, -1, 0, 1'b0, 0, 0);

        // Start pulse while busy must be ignored
        fill_rand(2);
        run_dl(8'h40, 2, -1, 0, 1'b0, 200, 0);

        // Length-1 file
        fill_rand(1);
        run_dl(8'hC3, 1, -1, 0, 1'b0, 0, 0);

        // Randomized downloads with random valid gaps
        for (int k = 0; k < 4; k++) begin
            int n;
            n = $urandom_range(0, 5);
            fill_rand(n);
            run_dl(8'($urandom), n, -1, 0, 1'b1, 0, 0);
        end

        // Reset in the middle of T2, right after data byte 1
        fill_rand(4);
        run_dl(8'h33, 4, -1, 0, 1'b0, 0, 6);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_ss2", 32'(spi_ss2), 32'd1);
        check("midrst_sck", 32'(spi_sck), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_din_ready", 32'(din_ready), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        fill_rand(2);
        run_dl(8'h5E, 2, -1, 0, 1'b0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
